// File: rtl/universal_shift_register.sv
// Universal shift register: shift, rotate, load and clear, with a bit counter that flags completed serial words.
// Single-cycle latency from the clk edge to q and word outputs; no backpressure, and en=0 freezes all state.
module universal_shift_register #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int             CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_valid,
  output logic [WIDTH-1:0] word_out
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             word_valid_q, word_valid_d;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             is_shift;

  always_comb begin
    q_d          = q_q;
    bit_cnt_d    = bit_cnt_q;
    word_valid_d = 1'b0;
    word_out_d   = word_out_q;
    is_shift     = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD:  q_d = q_q;
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], ser_in_l};
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {ser_in_r, q_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_LOAD: begin
          q_d       = par_in;
          bit_cnt_d = '0;
        end
        MODE_CLEAR: begin
          q_d       = '0;
          bit_cnt_d = '0;
        end
        default:    q_d = q_q;
      endcase
      // A shift on the last bit closes the word: capture the post-shift value.
      if (is_shift) begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d    = '0;
          word_valid_d = 1'b1;
          word_out_d   = q_d;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q          <= RESET_VAL;
      bit_cnt_q    <= '0;
      word_valid_q <= 1'b0;
      word_out_q   <= '0;
    end else begin
      q_q          <= q_d;
      bit_cnt_q    <= bit_cnt_d;
      word_valid_q <= word_valid_d;
      word_out_q   <= word_out_d;
    end
  end

  assign q           = q_q;
  assign ser_out_msb = q_q[WIDTH-1];
  assign ser_out_lsb = q_q[0];
  assign bit_cnt     = bit_cnt_q;
  assign word_valid  = word_valid_q;
  assign word_out    = word_out_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed vector bench for universal_shift_register at WIDTH=4.
module tb_universal_shift_register;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       ser_in_l;
  logic       ser_in_r;
  logic [3:0] par_in;
  logic [3:0] q;
  logic       ser_out_msb;
  logic       ser_out_lsb;
  logic [1:0] bit_cnt;
  logic       word_valid;
  logic [3:0] word_out;

  int n_vec  = 0;
  int n_miss = 0;

  universal_shift_register #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .par_in(par_in),
    .q(q), .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb),
    .bit_cnt(bit_cnt), .word_valid(word_valid), .word_out(word_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       sl;
    logic       sr;
    logic [3:0] par;
    logic [3:0] eq;
    logic [1:0] ec;
    logic       ewv;
    logic [3:0] ewo;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string tag, logic rst, logic e, logic [2:0] m, logic sl, logic sr,
                              logic [3:0] par, logic [3:0] eq, logic [1:0] ec, logic ewv, logic [3:0] ewo);
    vec_t v;
    v.tag = tag; v.rst = rst; v.en = e; v.mode = m; v.sl = sl; v.sr = sr; v.par = par;
    v.eq = eq; v.ec = ec; v.ewv = ewv; v.ewo = ewo;
    return v;
  endfunction

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic apply(input string tag, input logic rst, input logic e, input logic [2:0] m,
                       input logic sl, input logic sr, input logic [3:0] par,
                       input logic [3:0] eq, input logic [1:0] ec, input logic ewv, input logic [3:0] ewo);
    reset = rst; en = e; mode = m; ser_in_l = sl; ser_in_r = sr; par_in = par;
    @(posedge clk);
    #1;
    n_vec++;
    if ({q, ser_out_msb, ser_out_lsb, bit_cnt, word_valid, word_out} !==
        {eq, eq[3], eq[0], ec, ewv, ewo}) begin
      n_miss++;
      $display("FAIL %s (vec %0d): got q=%b msb=%b lsb=%b cnt=%0d wv=%b wo=%b, want q=%b msb=%b lsb=%b cnt=%0d wv=%b wo=%b",
               tag, n_vec, q, ser_out_msb, ser_out_lsb, bit_cnt, word_valid, word_out,
               eq, eq[3], eq[0], ec, ewv, ewo);
    end
  endtask

  initial begin
    logic [11:0] pat;
    logic [3:0]  mq, mwo;
    logic [1:0]  mc;
    logic        mwv;

    reset = 1'b1; en = 1'b0; mode = 3'b000; ser_in_l = 1'b0; ser_in_r = 1'b0; par_in = 4'h0;
    #2;

    //                tag        rst en mode   sl sr par      q        cnt   wv wo
    vq.push_back(mk("reset0",   1, 1, 3'b001, 1, 1, 4'h0, 4'b0000, 2'd0, 0, 4'b0000));
    vq.push_back(mk("reset1",   1, 1, 3'b001, 1, 1, 4'h0, 4'b0000, 2'd0, 0, 4'b0000));
    vq.push_back(mk("sipo1",    0, 1, 3'b001, 1, 0, 4'h0, 4'b0001, 2'd1, 0, 4'b0000));
    vq.push_back(mk("sipo2",    0, 1, 3'b001, 0, 0, 4'h0, 4'b0010, 2'd2, 0, 4'b0000));
    vq.push_back(mk("sipo3",    0, 1, 3'b001, 1, 0, 4'h0, 4'b0101, 2'd3, 0, 4'b0000));
    vq.push_back(mk("sipo4",    0, 1, 3'b001, 1, 0, 4'h0, 4'b1011, 2'd0, 1, 4'b1011));
    vq.push_back(mk("sipo5",    0, 1, 3'b001, 0, 0, 4'h0, 4'b0110, 2'd1, 0, 4'b1011));
    vq.push_back(mk("sipo6",    0, 1, 3'b001, 0, 0, 4'h0, 4'b1100, 2'd2, 0, 4'b1011));
    vq.push_back(mk("sipo7",    0, 1, 3'b001, 0, 0, 4'h0, 4'b1000, 2'd3, 0, 4'b1011));
    vq.push_back(mk("sipo8",    0, 1, 3'b001, 0, 0, 4'h0, 4'b0000, 2'd0, 1, 4'b0000));
    vq.push_back(mk("load1001", 0, 1, 3'b101, 0, 0, 4'h9, 4'b1001, 2'd0, 0, 4'b0000));
    vq.push_back(mk("ror",      0, 1, 3'b100, 0, 0, 4'h0, 4'b1100, 2'd0, 0, 4'b0000));
    vq.push_back(mk("rol1",     0, 1, 3'b011, 0, 0, 4'h0, 4'b1001, 2'd0, 0, 4'b0000));
    vq.push_back(mk("rol2",     0, 1, 3'b011, 0, 0, 4'h0, 4'b0011, 2'd0, 0, 4'b0000));
    vq.push_back(mk("piso_ld",  0, 1, 3'b101, 0, 0, 4'hA, 4'b1010, 2'd0, 0, 4'b0000));
    vq.push_back(mk("piso1",    0, 1, 3'b010, 0, 0, 4'h0, 4'b0101, 2'd1, 0, 4'b0000));
    vq.push_back(mk("piso2",    0, 1, 3'b010, 0, 0, 4'h0, 4'b0010, 2'd2, 0, 4'b0000));
    vq.push_back(mk("piso3",    0, 1, 3'b010, 0, 0, 4'h0, 4'b0001, 2'd3, 0, 4'b0000));
    vq.push_back(mk("piso4",    0, 1, 3'b010, 0, 0, 4'h0, 4'b0000, 2'd0, 1, 4'b0000));
    vq.push_back(mk("gap_sh1",  0, 1, 3'b001, 1, 0, 4'h0, 4'b0001, 2'd1, 0, 4'b0000));
    vq.push_back(mk("gap_sh2",  0, 1, 3'b001, 1, 0, 4'h0, 4'b0011, 2'd2, 0, 4'b0000));
    vq.push_back(mk("gap_off1", 0, 0, 3'b001, 1, 0, 4'h0, 4'b0011, 2'd2, 0, 4'b0000));
    vq.push_back(mk("gap_off2", 0, 0, 3'b001, 1, 0, 4'h0, 4'b0011, 2'd2, 0, 4'b0000));
    vq.push_back(mk("gap_off3", 0, 0, 3'b001, 1, 0, 4'h0, 4'b0011, 2'd2, 0, 4'b0000));
    vq.push_back(mk("gap_sh3",  0, 1, 3'b001, 1, 0, 4'h0, 4'b0111, 2'd3, 0, 4'b0000));
    vq.push_back(mk("gap_sh4",  0, 1, 3'b001, 1, 0, 4'h0, 4'b1111, 2'd0, 1, 4'b1111));
    vq.push_back(mk("mid_sh1",  0, 1, 3'b001, 0, 0, 4'h0, 4'b1110, 2'd1, 0, 4'b1111));
    vq.push_back(mk("mid_sh2",  0, 1, 3'b001, 0, 0, 4'h0, 4'b1100, 2'd2, 0, 4'b1111));
    vq.push_back(mk("mid_sh3",  0, 1, 3'b001, 0, 0, 4'h0, 4'b1000, 2'd3, 0, 4'b1111));
    vq.push_back(mk("mid_rst",  1, 1, 3'b001, 1, 0, 4'h0, 4'b0000, 2'd0, 0, 4'b0000));
    vq.push_back(mk("post_rs1", 0, 1, 3'b001, 1, 0, 4'h0, 4'b0001, 2'd1, 0, 4'b0000));
    vq.push_back(mk("post_rs2", 0, 1, 3'b001, 1, 0, 4'h0, 4'b0011, 2'd2, 0, 4'b0000));
    vq.push_back(mk("post_rs3", 0, 1, 3'b001, 1, 0, 4'h0, 4'b0111, 2'd3, 0, 4'b0000));
    vq.push_back(mk("post_rs4", 0, 1, 3'b001, 1, 0, 4'h0, 4'b1111, 2'd0, 1, 4'b1111));
    vq.push_back(mk("ld_after", 0, 1, 3'b101, 0, 0, 4'h5, 4'b0101, 2'd0, 0, 4'b1111));
    vq.push_back(mk("shr_one",  0, 1, 3'b010, 0, 1, 4'h0, 4'b1010, 2'd1, 0, 4'b1111));
    vq.push_back(mk("rol_cnt",  0, 1, 3'b011, 0, 0, 4'h0, 4'b0101, 2'd1, 0, 4'b1111));
    vq.push_back(mk("hold",     0, 1, 3'b000, 1, 1, 4'hF, 4'b0101, 2'd1, 0, 4'b1111));
    vq.push_back(mk("reserved", 0, 1, 3'b111, 1, 1, 4'hF, 4'b0101, 2'd1, 0, 4'b1111));
    vq.push_back(mk("en0_load", 0, 0, 3'b101, 0, 0, 4'h9, 4'b0101, 2'd1, 0, 4'b1111));
    vq.push_back(mk("clear",    0, 1, 3'b110, 0, 0, 4'h0, 4'b0000, 2'd0, 0, 4'b1111));
    vq.push_back(mk("dir_r1",   0, 1, 3'b010, 0, 1, 4'h0, 4'b1000, 2'd1, 0, 4'b1111));
    vq.push_back(mk("dir_l2",   0, 1, 3'b001, 1, 0, 4'h0, 4'b0001, 2'd2, 0, 4'b1111));
    vq.push_back(mk("dir_r3",   0, 1, 3'b010, 0, 1, 4'h0, 4'b1000, 2'd3, 0, 4'b1111));
    vq.push_back(mk("dir_l4",   0, 1, 3'b001, 0, 0, 4'h0, 4'b0000, 2'd0, 1, 4'b0000));
    vq.push_back(mk("clr_aft",  0, 1, 3'b110, 0, 0, 4'h0, 4'b0000, 2'd0, 0, 4'b0000));

    for (int i = 0; i < vq.size(); i++)
      apply(vq[i].tag, vq[i].rst, vq[i].en, vq[i].mode, vq[i].sl, vq[i].sr, vq[i].par,
            vq[i].eq, vq[i].ec, vq[i].ewv, vq[i].ewo);

    // Back-to-back words: 12 continuous left shifts, expecting a pulse every 4th cycle.
    apply("b2b_rst", 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    pat = 12'b1011_0110_0011;
    mq = 4'b0000; mc = 2'd0; mwo = 4'b0000;
    for (int i = 11; i >= 0; i--) begin
      mq  = {mq[2:0], pat[i]};
      mc  = mc + 2'd1;
      mwv = (mc == 2'd0);
      if (mwv) mwo = mq;
      apply("b2b_shift", 1'b0, 1'b1, 3'b001, pat[i], 1'b0, 4'h0, mq, mc, mwv, mwo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised universal shift register that generalises the team's 4-bit SISO shifter. It adds configurable width, bidirectional serial shifting, rotate, parallel load and clear. A built-in bit counter flags each completed serial word, so the block can act as a SIPO deserialiser or a PISO serialiser in the serial-link datapath.

Parameters:
WIDTH, 4, register width in bits; legal range is WIDTH >= 2.
RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
CNT_W, $clog2(WIDTH), localparam; width of bit_cnt.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  operation enable; when low, all state holds
mode  input  3  operation select (see Behaviour)
ser_in_l  input  1  serial bit shifted into q[0] on shift-left
ser_in_r  input  1  serial bit shifted into q[WIDTH-1] on shift-right
par_in  input  WIDTH  parallel load data
q  output  WIDTH  register contents (registered)
ser_out_msb  output  1  q[WIDTH-1], combinational from q
ser_out_lsb  output  1  q[0], combinational from q
bit_cnt  output  CNT_W  shifts completed in the current word, 0..WIDTH-1
word_valid  output  1  single-cycle pulse when a word completes
word_out  output  WIDTH  captured completed word (registered)

Behaviour:
- Reset (sampled at the clk edge, has priority over en and mode):
  - q = RESET_VAL, bit_cnt = 0, word_valid = 0, word_out = 0.
- en = 0: q, bit_cnt and word_out hold; word_valid = 0.
- en = 1, mode decoded at the clk edge; the result is visible in q one cycle later:
  - 000 hold: q unchanged.
  - 001 shift left: q <= {q[WIDTH-2:0], ser_in_l}.
  - 010 shift right: q <= {ser_in_r, q[WIDTH-1:1]}.
  - 011 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 101 parallel load: q <= par_in.
  - 110 clear: q <= 0.
  - 111 reserved: behaves exactly as hold.
- Bit counter:
  - Increments only on the shift modes 001 and 010, in either direction; a direction change mid-word does not reset it.
  - Rotate, hold and reserved leave bit_cnt unchanged.
  - Load and clear set bit_cnt = 0.
  - Shifting with bit_cnt == WIDTH-1 wraps bit_cnt to 0.
- Word completion:
  - On the edge where bit_cnt wraps, word_valid = 1 for exactly one cycle.
  - On that same edge, word_out = the post-shift value of q, so word_out equals q in the word_valid cycle.
  - word_out holds until the next completion or reset.
- Back-to-back words: continuous shifting produces a word_valid pulse every WIDTH cycles with no gap cycles.
- Load or clear on the edge following a completion: word_valid still deasserts normally, and word_out is unaffected.
- ser_out_msb and ser_out_lsb track q with no added latency. For PISO use, load once, then shift WIDTH times.

Test Plan:
1. Reset check (WIDTH=4): hold reset high for 2 cycles with en=1 and mode=001 -> q=0000, bit_cnt=0, word_valid=0, word_out=0.
2. SIPO: from 0000, shift left with ser_in_l = 1,0,1,1 -> q=0001, 0010, 0101, 1011; word_valid=1 only in the 4th cycle with word_out=1011 and bit_cnt=0; continuing with 0,0,0,0 gives the next pulse 4 cycles later with word_out=0000.
3. Load/rotate: load 1001 -> bit_cnt=0, q=1001; rotate right -> 1100; rotate left twice -> 1001 then 0011; word_valid never asserts and bit_cnt stays 0.
4. PISO: load 1010, then shift right with ser_in_r=0 for 4 cycles -> ser_out_lsb before each shift = 0,1,0,1; final q=0000; word_valid pulses on the 4th shift with word_out=0000.
5. Enable gaps: shift left twice with ser_in_l=1, drop en for 3 cycles (mode=001 held), then shift twice more with ser_in_l=1 -> q and bit_cnt=2 frozen during the gap; word_valid fires on the 4th actual shift with word_out=1111.
6. Reset mid-word: after 3 shifts, assert reset for 1 cycle while en=1 and mode=001 -> q=0000, bit_cnt=0, no word_valid; a full 4 further shifts are needed before the next word_valid.
